// File: rtl/pipeline_trace_monitor.sv
// pipeline_trace_monitor
// Observability block that sits beside the 5-stage RISC-V core. It counts
// run cycles, retirements, stalls, flushes and forwarding events, detects
// the end of a program (cycle limit or a run of all-zero fetches), and keeps
// a circular trace of the most recent writeback retirements. The trace can
// be read back at any time through a registered index port.

module pipeline_trace_monitor #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 500,
  parameter int NOP_RUN    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [1:0]               fwd_a,
  input  logic [1:0]               fwd_b,
  input  logic [31:0]              if_instr,
  input  logic                     rd_req,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_data,
  output logic [4:0]               rd_rd,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt,
  output logic [CNT_W-1:0]         fwd_cnt,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic                     halted,
  output logic [1:0]               halt_cause
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(NOP_RUN + 1);

  // Counter ceiling; counters stick here instead of wrapping.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // MAX_CYCLES widened so the comparison is exact even when MAX_CYCLES
  // exceeds what a narrow counter can represent (then it simply never hits).
  localparam logic [CNT_W+31:0] MAX_CYC_EXT = (CNT_W + 32)'(MAX_CYCLES);
  localparam logic [NW-1:0]     NOP_LIMIT   = NW'(NOP_RUN);
  localparam logic [AW:0]       FULL_COUNT  = (AW + 1)'(DEPTH);

  localparam logic [1:0] CAUSE_MAX_CYCLES = 2'b01;
  localparam logic [1:0] CAUSE_NOP_RUN    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_fwd_cnt;
  logic [NW-1:0]    r_nop_cnt;
  logic [1:0]       r_halt_cause;
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_trace_count;
  logic             r_overflow;
  logic             r_rd_valid;
  logic             r_rd_err;
  logic [XLEN-1:0]  r_rd_pc;
  logic [XLEN-1:0]  r_rd_data;
  logic [4:0]       r_rd_rd;
  entry_t           r_mem [DEPTH];

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  state_t           w_state_next;
  logic             w_active;
  logic [CNT_W-1:0] w_cycle_next;
  logic [NW-1:0]    w_nop_next;
  logic             w_hit_max;
  logic             w_hit_nop;
  logic             w_halt;
  logic             w_write;
  logic [AW-1:0]    w_rd_addr;
  logic             w_rd_err;
  entry_t           w_rd_entry;

  // Statistics, halt detection and trace writes only advance in an enabled
  // RUN cycle; the cycle en is first seen in IDLE is not counted.
  assign w_active     = (r_state == ST_RUN) && en;
  assign w_cycle_next = sat_inc(r_cycle_cnt, 1'b1);
  assign w_nop_next   = (if_instr == 32'd0) ? r_nop_cnt + NW'(1) : '0;
  assign w_hit_max    = ({32'd0, w_cycle_next} == MAX_CYC_EXT);
  assign w_hit_nop    = (w_nop_next == NOP_LIMIT);
  assign w_halt       = w_active && (w_hit_max || w_hit_nop);
  assign w_write      = w_active && wb_valid;

  // Logical index 0 is the oldest entry, which sits trace_count slots behind
  // the write pointer. When the buffer is full the low bits of the count are
  // zero, so the oldest entry is the slot about to be overwritten.
  assign w_rd_addr  = r_wptr - r_trace_count[AW-1:0] + rd_idx;
  assign w_rd_err   = ({1'b0, rd_idx} >= r_trace_count);
  assign w_rd_entry = r_mem[w_rd_addr];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the block order.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: enable starts/pauses a run; a halt is sticky.
  always_comb begin
    // NOTE: defaulting the output first means every path assigns it, so no
    // latch is inferred when a case arm does not change state.
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (en) w_state_next = ST_RUN;
      ST_RUN: begin
        if (!en)         w_state_next = ST_IDLE;
        else if (w_halt) w_state_next = ST_HALTED;
      end
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Statistics and halt cause
  // ---------------------------------------------------------------------

  // Saturating event counters and the zero-fetch run length, RUN cycles only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_fwd_cnt    <= '0;
      r_nop_cnt    <= '0;
      r_halt_cause <= 2'b00;
    end else if (w_active) begin
      r_cycle_cnt  <= w_cycle_next;
      r_retire_cnt <= sat_inc(r_retire_cnt, wb_valid);
      r_stall_cnt  <= sat_inc(r_stall_cnt, stall);
      r_flush_cnt  <= sat_inc(r_flush_cnt, flush);
      r_fwd_cnt    <= sat_inc(r_fwd_cnt, (fwd_a != 2'b00) || (fwd_b != 2'b00));
      r_nop_cnt    <= w_nop_next;
      // The cycle limit wins when both conditions land on the same cycle.
      if (w_halt) r_halt_cause <= w_hit_max ? CAUSE_MAX_CYCLES : CAUSE_NOP_RUN;
    end
  end

  // ---------------------------------------------------------------------
  // Trace buffer
  // ---------------------------------------------------------------------

  // Write pointer, occupancy and the sticky overwrite flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr        <= '0;
      r_trace_count <= '0;
      r_overflow    <= 1'b0;
    end else if (w_write) begin
      r_wptr <= r_wptr + AW'(1);
      if (r_trace_count == FULL_COUNT) r_overflow    <= 1'b1;
      else                             r_trace_count <= r_trace_count + (AW + 1)'(1);
    end
  end

  // Trace storage: one entry per retirement, x0 writes included.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale entries are unreachable
    // because reads are bounded by trace_count, which reset does clear.
    if (!reset && w_write) r_mem[r_wptr] <= '{pc: wb_pc, rd: wb_rd, data: wb_data};
  end

  // Registered read port; it sees the array before any same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_data  <= '0;
      r_rd_rd    <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_err <= w_rd_err;
        if (w_rd_err) begin
          r_rd_pc   <= '0;
          r_rd_data <= '0;
          r_rd_rd   <= '0;
        end else begin
          r_rd_pc   <= w_rd_entry.pc;
          r_rd_data <= w_rd_entry.data;
          r_rd_rd   <= w_rd_entry.rd;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cycle_cnt   = r_cycle_cnt;
  assign retire_cnt  = r_retire_cnt;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign fwd_cnt     = r_fwd_cnt;
  assign trace_count = r_trace_count;
  assign overflow    = r_overflow;
  assign halted      = (r_state == ST_HALTED);
  assign halt_cause  = r_halt_cause;
  assign rd_valid    = r_rd_valid;
  assign rd_err      = r_rd_err;
  assign rd_pc       = r_rd_pc;
  assign rd_data     = r_rd_data;
  assign rd_rd       = r_rd_rd;

endmodule
